// File: rtl/gcd_engine.sv
// GCD engine: subtractive Euclid or binary (Stein) reduction, one step per clock,
// with a start/done handshake, a both-zero error flag and an iteration count.
module gcd_engine #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] gcd_out,
  output logic             err,
  output logic [CNT_W-1:0] cycles
);

  localparam int unsigned K_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN_S,
    S_RUN_B,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [K_W-1:0]   k;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  // Iteration count saturates instead of wrapping.
  assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      a_r     <= '0;
      b_r     <= '0;
      k       <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      gcd_out <= '0;
      err     <= 1'b0;
      cycles  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            a_r  <= a_in;
            b_r  <= b_in;
            k    <= '0;
            cnt  <= '0;
            busy <= 1'b1;
            // A zero operand short-circuits: gcd(x,0) = x, gcd(0,0) is flagged.
            if (a_in == '0 || b_in == '0) begin
              gcd_out <= a_in | b_in;
              err     <= (a_in == '0) && (b_in == '0);
              cycles  <= '0;
              done    <= 1'b1;
              state   <= S_DONE;
            end else begin
              state <= mode ? S_RUN_B : S_RUN_S;
            end
          end
        end

        S_RUN_S: begin
          cnt <= cnt_inc;
          if (a_r == b_r) begin
            gcd_out <= a_r;
            cycles  <= cnt_inc;
            err     <= 1'b0;
            done    <= 1'b1;
            state   <= S_DONE;
          end else if (a_r < b_r) begin
            b_r <= b_r - a_r;
          end else begin
            a_r <= a_r - b_r;
          end
        end

        S_RUN_B: begin
          cnt <= cnt_inc;
          if (!a_r[0] && !b_r[0]) begin
            a_r <= a_r >> 1;
            b_r <= b_r >> 1;
            k   <= k + K_W'(1);
          end else if (!a_r[0]) begin
            a_r <= a_r >> 1;
          end else if (!b_r[0]) begin
            b_r <= b_r >> 1;
          end else if (a_r == b_r) begin
            // Common factor of two restored; cannot exceed the original operands.
            gcd_out <= a_r << k;
            cycles  <= cnt_inc;
            err     <= 1'b0;
            done    <= 1'b1;
            state   <= S_DONE;
          end else if (a_r > b_r) begin
            a_r <= a_r - b_r;
          end else begin
            b_r <= b_r - a_r;
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboard bench for gcd_engine: directed cases on an 8-bit instance,
// random sweeps on 8-bit and 16-bit instances against a modulo-Euclid model.
module tb_gcd_engine;

  typedef struct {
    logic [15:0] gcd;
    logic        err;
    logic [15:0] cyc;
    logic        chk_cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start8;
  logic        start16;
  logic        mode_drv;
  logic [15:0] a_drv;
  logic [15:0] b_drv;

  logic        busy8, done8, err8;
  logic [7:0]  gcd8;
  logic [15:0] cyc8;
  logic        busy16, done16, err16;
  logic [15:0] gcd16;
  logic [15:0] cyc16;

  exp_t q8[$];
  exp_t q16[$];
  int   n_cmp;
  int   n_bad;
  int   n_start8, n_start16, n_done8, n_done16;

  gcd_engine #(.WIDTH(8), .CNT_W(16)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode_drv),
    .a_in(a_drv[7:0]), .b_in(b_drv[7:0]),
    .busy(busy8), .done(done8), .gcd_out(gcd8), .err(err8), .cycles(cyc8)
  );

  gcd_engine #(.WIDTH(16), .CNT_W(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .mode(mode_drv),
    .a_in(a_drv), .b_in(b_drv),
    .busy(busy16), .done(done16), .gcd_out(gcd16), .err(err16), .cycles(cyc16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_gcd(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Output side of the scoreboard: every done pulse pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done8) begin
      n_done8++;
      if (q8.size() == 0) check_eq("spurious_done8", done8, 0);
      else begin
        e = q8.pop_front();
        check_eq("gcd8", gcd8, e.gcd);
        check_eq("err8", err8, e.err);
        if (e.chk_cyc) check_eq("cycles8", cyc8, e.cyc);
      end
    end
    if (done16) begin
      n_done16++;
      if (q16.size() == 0) check_eq("spurious_done16", done16, 0);
      else begin
        e = q16.pop_front();
        check_eq("gcd16", gcd16, e.gcd);
        check_eq("err16", err16, e.err);
        if (e.chk_cyc) check_eq("cycles16", cyc16, e.cyc);
      end
    end
  end

  // Called at a negedge with the DUT idle; returns one cycle after done.
  task automatic run_op(input bit wide, input logic m, input logic [15:0] a, input logic [15:0] b,
                        input int exp_cyc, input int poke, input string tag);
    exp_t e;
    int   edges;
    int   to;
    e.gcd     = ref_gcd(a, b);
    e.err     = (a == 0) && (b == 0);
    e.cyc     = (exp_cyc >= 0) ? 16'(exp_cyc) : 16'd0;
    e.chk_cyc = (exp_cyc >= 0);
    if (wide) begin q16.push_back(e); n_start16++; end
    else begin q8.push_back(e); n_start8++; end
    mode_drv = m;
    a_drv    = a;
    b_drv    = b;
    if (wide) start16 = 1'b1; else start8 = 1'b1;
    @(posedge clk);
    #1;
    start8  = 1'b0;
    start16 = 1'b0;
    check_eq({tag, "_busy_hi"}, wide ? busy16 : busy8, 1);
    edges = 1;
    to    = 0;
    @(negedge clk);
    while (!(wide ? done16 : done8) && to < 70000) begin
      if (poke > 0 && to == poke) begin
        a_drv    = a ^ 16'h005a;
        b_drv    = 16'h0003;
        mode_drv = ~m;
        if (wide) start16 = 1'b1; else start8 = 1'b1;
      end else if (poke > 0 && to == poke + 1) begin
        start8  = 1'b0;
        start16 = 1'b0;
      end
      @(posedge clk);
      edges++;
      to++;
      @(negedge clk);
    end
    start8  = 1'b0;
    start16 = 1'b0;
    if (!(wide ? done16 : done8)) check_eq({tag, "_timeout"}, wide ? done16 : done8, 1);
    else if (exp_cyc >= 0) check_eq({tag, "_latency"}, edges, exp_cyc + 1);
    @(negedge clk);
    check_eq({tag, "_busy_lo"}, wide ? busy16 : busy8, 0);
    check_eq({tag, "_done_lo"}, wide ? done16 : done8, 0);
  endtask

  initial begin
    logic        m;
    logic [15:0] a, b;
    n_cmp = 0; n_bad = 0;
    n_start8 = 0; n_start16 = 0; n_done8 = 0; n_done16 = 0;
    rst = 1'b1; start8 = 1'b0; start16 = 1'b0; mode_drv = 1'b0; a_drv = '0; b_drv = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", busy8, 0);
    check_eq("rst_done", done8, 0);
    check_eq("rst_gcd", gcd8, 0);
    check_eq("rst_err", err8, 0);
    check_eq("rst_cycles", cyc8, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(0, 1'b0, 16'd12, 16'd18, 3, 0, "s12_18");
    run_op(0, 1'b1, 16'd12, 16'd18, 5, 0, "b12_18");
    run_op(0, 1'b1, 16'd48, 16'd36, 7, 0, "b48_36");
    run_op(0, 1'b0, 16'd0,  16'd20, 0, 0, "z0_20");
    run_op(0, 1'b1, 16'd0,  16'd0,  0, 0, "z0_0");
    run_op(0, 1'b0, 16'd1,  16'd255, 255, 10, "s1_255");

    // Abandon gcd(12,18) with a reset in its second RUN cycle.
    mode_drv = 1'b0; a_drv = 16'd12; b_drv = 16'd18; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_done", done8, 0);
    check_eq("abort_busy", busy8, 0);
    check_eq("abort_gcd", gcd8, 0);
    check_eq("abort_err", err8, 0);
    check_eq("abort_cycles", cyc8, 0);
    rst = 1'b0;
    run_op(0, 1'b1, 16'd7, 16'd7, 1, 0, "b7_7");

    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom_range(0, 1));
      a = 16'($urandom_range(0, 255));
      b = 16'($urandom_range(0, 255));
      run_op(0, m, a, b, -1, 0, "rnd8");
    end
    for (int i = 0; i < 30; i++) begin
      m = 1'($urandom_range(0, 1));
      if (m) begin
        a = 16'($urandom_range(1, 65535));
        b = 16'($urandom_range(1, 65535));
      end else begin
        a = 16'($urandom_range(256, 65535));
        b = 16'($urandom_range(256, 65535));
      end
      run_op(1, m, a, b, -1, 0, "rnd16");
    end

    repeat (3) @(negedge clk);
    check_eq("q8_empty", q8.size(), 0);
    check_eq("q16_empty", q16.size(), 0);
    check_eq("done_count8", n_done8, n_start8);
    check_eq("done_count16", n_done16, n_start16);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
